rt_pixel_sequencer: RTL and testbench

- Frame-level pixel scanner directly upstream of the ray generation unit (rt_rgu).
- On a frame start it walks every pixel of a W×H image in raster order (x inner, y outer).
- Emits pixel coordinates in Q14.18 fixed point with a valid/ready handshake; the RGU consumes them as x/y with valid driving its start input.
- Counts returned RGU valids so that frame completion is signalled only after the pipeline has fully drained.

---
 rtl/rt_pkg.sv | 25 ++
 rtl/rt_pixel_sequencer_if.sv | 19 +
 rtl/rt_raster_counter.sv | 58 +++++
 rtl/rt_pixel_sequencer.sv | 149 ++++++++++++++
 tb/tb_rt_pixel_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rt_pkg.sv
// Shared definitions for the ray-tracing front end.
//   FRAC_BITS   : fractional bits of emitted coordinates (Q14.18, 1.0 = 0x00040000)
//   coord_t     : 32-bit signed-range fixed-point coordinate
//   seq_state_t : pixel sequencer frame state
//   int_to_coord: integer pixel index -> fixed-point coordinate
package rt_pkg;

    localparam int FRAC_BITS = 18;
    localparam int COORD_W   = 32;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Dimensions are capped at 2^13, so the shifted value never reaches the sign bit.
    function automatic coord_t int_to_coord(input logic [COORD_W-1:0] v, input int frac);
        return coord_t'(v << frac);
    endfunction

endpackage

// File: rtl/rt_pixel_sequencer_if.sv
// Pixel coordinate stream from the sequencer to the ray generation unit.
//   pix_valid : coordinate valid (drives RGU start)
//   pix_ready : downstream may accept a coordinate
//   pix_x/y   : Q14.18 coordinates
//   pix_last  : final pixel of the frame
// Modports: master (sequencer side), slave (RGU side).
interface rt_pixel_sequencer_if;
    import rt_pkg::*;

    logic   pix_valid;
    logic   pix_ready;
    coord_t pix_x;
    coord_t pix_y;
    logic   pix_last;

    modport master (output pix_valid, pix_x, pix_y, pix_last, input pix_ready);
    modport slave  (input pix_valid, pix_x, pix_y, pix_last, output pix_ready);

endinterface

// File: rtl/rt_raster_counter.sv
// Raster-order x/y counter: x increments on en_i and wraps at width-1, carrying into y.
//   clk, reset      : clock, asynchronous active-high reset
//   clear_i         : return to (0,0); has priority over en_i
//   en_i            : advance one pixel
//   width_i/height_i: frame dimensions (held stable by the caller during a frame)
//   x_o, y_o        : current pixel position
//   last_o          : current position is the final pixel of the frame
module rt_raster_counter #(
    parameter int DIM_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    output logic [DIM_W-1:0] x_o,
    output logic [DIM_W-1:0] y_o,
    output logic             last_o
);

    logic [DIM_W-1:0] x_q, x_d;
    logic [DIM_W-1:0] y_q, y_d;
    logic             x_wrap;

    always_comb begin
        x_wrap = (x_q == width_i - DIM_W'(1));
        x_d    = x_q;
        y_d    = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (x_wrap) begin
                x_d = '0;
                y_d = y_q + DIM_W'(1);
            end else begin
                x_d = x_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    // Derived from registered position only, so it stays aligned with the held coordinate.
    assign last_o = x_wrap && (y_q == height_i - DIM_W'(1));

endmodule

// File: rtl/rt_pixel_sequencer.sv
// Frame pixel scanner feeding the ray generation unit.
// Walks a width x height frame in raster order, emitting Q14.18 coordinates on a
// valid/ready stream, then waits for every issued pixel to come back as a ray
// before pulsing done.
//   clk, reset         : clock, asynchronous active-high reset
//   start, width/height: frame request (accepted only when idle)
//   pix                : coordinate stream (master side)
//   ray_valid          : one returned ray per high cycle
//   busy, done         : frame in progress / one-cycle completion pulse
//   protocol_err       : sticky, ray returned with nothing outstanding
// Optional macro RT_SEQ_PERF_EN adds frame_cycles and stall_cycles outputs.
module rt_pixel_sequencer #(
    parameter int DIM_W     = 16,
    parameter int FRAC_BITS = rt_pkg::FRAC_BITS,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DIM_W-1:0]     width,
    input  logic [DIM_W-1:0]     height,
    rt_pixel_sequencer_if.master pix,
    input  logic                 ray_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 protocol_err
`ifdef RT_SEQ_PERF_EN
    ,
    output logic [31:0]          frame_cycles,
    output logic [31:0]          stall_cycles
`endif
);
    import rt_pkg::*;

    seq_state_t       state_q, state_d;
    logic [DIM_W-1:0] w_q, h_q;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] returned_q, returned_d;
    logic             perr_q, perr_d;

    logic             start_acc;
    logic             xfer;
    logic             outstanding;
    logic [DIM_W-1:0] cur_x, cur_y;
    logic             cur_last;

    assign start_acc   = (state_q == IDLE) && start;
    assign xfer        = (state_q == SCAN) && pix.pix_ready;
    assign outstanding = (issued_q != returned_q);

    rt_raster_counter #(.DIM_W(DIM_W)) u_raster (
        .clk     (clk),
        .reset   (reset),
        .clear_i (start_acc),
        .en_i    (xfer),
        .width_i (w_q),
        .height_i(h_q),
        .x_o     (cur_x),
        .y_o     (cur_y),
        .last_o  (cur_last)
    );

    always_comb begin
        issued_d   = issued_q;
        returned_d = returned_q;
        perr_d     = perr_q;
        state_d    = state_q;

        if (start_acc) begin
            issued_d   = '0;
            returned_d = '0;
            perr_d     = 1'b0;
        end else begin
            if (xfer)
                issued_d = issued_q + CNT_W'(1);
            if (ray_valid && outstanding)
                returned_d = returned_q + CNT_W'(1);
        end
        // A stray ray always registers, even in the cycle a start clears the flag.
        if (ray_valid && !outstanding)
            perr_d = 1'b1;

        case (state_q)
            IDLE:  if (start)
                       state_d = (width == '0 || height == '0) ? DONE : SCAN;
            SCAN:  if (xfer && cur_last)
                       state_d = DRAIN;
            // Compare next-state counters so the final ray exits in its own cycle.
            DRAIN: if (returned_d == issued_d)
                       state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            w_q        <= '0;
            h_q        <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            perr_q     <= perr_d;
            if (start_acc) begin
                w_q <= width;
                h_q <= height;
            end
        end
    end

    assign pix.pix_valid = (state_q == SCAN);
    assign pix.pix_x     = int_to_coord(32'(cur_x), FRAC_BITS);
    assign pix.pix_y     = int_to_coord(32'(cur_y), FRAC_BITS);
    assign pix.pix_last  = cur_last;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign protocol_err  = perr_q;

`ifdef RT_SEQ_PERF_EN
    logic [31:0] frame_q, stall_q;

    // The start cycle itself counts, hence loading 1; the DONE cycle is the last counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
            stall_q <= '0;
        end else begin
            if (start_acc)
                frame_q <= 32'd1;
            else if (state_q != IDLE)
                frame_q <= frame_q + 32'd1;

            if (start_acc)
                stall_q <= '0;
            else if (state_q == SCAN && !pix.pix_ready)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign frame_cycles = frame_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_rt_pixel_sequencer.sv
module tb_rt_pixel_sequencer;
    import rt_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] width, height;
    logic        ray_valid;
    logic        busy, done, protocol_err;
`ifdef RT_SEQ_PERF_EN
    logic [31:0] frame_cycles, stall_cycles;
`endif

    rt_pixel_sequencer_if pif();

    rt_pixel_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .width       (width),
        .height      (height),
        .pix         (pif),
        .ray_valid   (ray_valid),
        .busy        (busy),
        .done        (done),
        .protocol_err(protocol_err)
`ifdef RT_SEQ_PERF_EN
        ,
        .frame_cycles(frame_cycles),
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int x;
        int y;
        bit last;
    } pix_t;

    // Table record: inputs (w, h, ready mode, ray latency) and expected outputs.
    typedef struct {
        int w;
        int h;
        int rmode;      // 0: always ready, 1: ready pattern 1,0,0, 2: random
        int lat;        // ray return latency, 0 = random 1..8
        int exp_pix;
        int exp_stall;  // -1 = take from observed stalls
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Runs one frame from the idle state and checks it against a raster-order model.
    task automatic run_frame(input int w, input int h, input int rmode, input int lat,
                             input int exp_pix, input int exp_stall, input bit restart);
        pix_t expq[$];
        int   dueq[$];
        int   s, k, guard, xfer_cnt, done_cnt, done_cyc, last_xfer, last_ray, stall_obs, exp_done;
        bit   prev_stall, busy_bad, rdy, timed_out;
        logic [31:0] hx, hy;
        logic hl;
        pix_t e;

        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                expq.push_back('{xx, yy, (xx == w-1) && (yy == h-1)});

        s = cyc;
        start = 1'b1;
        width = 16'(w);
        height = 16'(h);
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("perr_cleared", protocol_err, 0);
        if (exp_pix > 0) begin
            check("first_valid", pif.pix_valid, 1);
            check("first_x", pif.pix_x, 0);
            check("first_y", pif.pix_y, 0);
        end

        xfer_cnt = 0; done_cnt = 0; done_cyc = -1; last_xfer = -1; last_ray = -1;
        stall_obs = 0; prev_stall = 0; busy_bad = 0; guard = 0; timed_out = 0;
        hx = '0; hy = '0; hl = 1'b0;

        while (!(done_cnt > 0 && cyc >= done_cyc + 3)) begin
            if (guard++ > 3000) begin
                timed_out = 1;
                break;
            end
            k = cyc - (s + 1);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cnt == 0 && !busy) busy_bad = 1;
            if (prev_stall) begin
                check("stall_valid_held", pif.pix_valid, 1);
                check("stall_x_held", pif.pix_x, hx);
                check("stall_y_held", pif.pix_y, hy);
                check("stall_last_held", pif.pix_last, hl);
            end

            case (rmode)
                0: rdy = 1'b1;
                1: rdy = (k % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            pif.pix_ready = rdy;

            if (dueq.size() > 0 && dueq[0] <= cyc) begin
                ray_valid = 1'b1;
                void'(dueq.pop_front());
                last_ray = cyc;
            end else begin
                ray_valid = 1'b0;
            end

            if (restart && k == 4) begin
                start = 1'b1; width = 16'd2; height = 16'd2;
            end else begin
                start = 1'b0;
            end

            if (pif.pix_valid && rdy) begin
                if (expq.size() == 0) begin
                    check("extra_pixel", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("pix_x", pif.pix_x, 64'(e.x) * 64'h40000);
                    check("pix_y", pif.pix_y, 64'(e.y) * 64'h40000);
                    check("pix_last", pif.pix_last, e.last);
                end
                xfer_cnt++;
                last_xfer = cyc;
                dueq.push_back(cyc + ((lat == 0) ? int'($urandom_range(1, 8)) : lat));
            end
            prev_stall = pif.pix_valid && !rdy;
            if (prev_stall) stall_obs++;
            hx = pif.pix_x; hy = pif.pix_y; hl = pif.pix_last;
            tick();
        end
        ray_valid = 1'b0;
        start = 1'b0;
        pif.pix_ready = 1'b0;

        check("timeout", timed_out, 0);
        check("pixel_count", xfer_cnt, exp_pix);
        check("missing_pixels", expq.size(), 0);
        check("done_count", done_cnt, 1);
        check("busy_during_frame", busy_bad, 0);
        if (exp_pix == 0)
            exp_done = s + 1;
        else
            exp_done = (last_ray + 1 > last_xfer + 2) ? last_ray + 1 : last_xfer + 2;
        check("done_cycle", done_cyc, exp_done);
        check("idle_after_done", busy, 0);
        check("perr_after_frame", protocol_err, 0);
`ifdef RT_SEQ_PERF_EN
        check("frame_cycles", frame_cycles, done_cyc - s + 1);
        check("stall_cycles", stall_cycles, (exp_stall < 0) ? stall_obs : exp_stall);
`endif
        $display("frame %0dx%0d rmode=%0d: %0d pixels, done at cycle %0d", w, h, rmode, xfer_cnt, done_cyc);
    endtask

    vec_t vecs[9];
    int   nx, w, h;

    initial begin
        vecs[0] = '{3, 2, 0, 5, 6, 0};
        vecs[1] = '{3, 2, 1, 5, 6, 10};
        vecs[2] = '{0, 5, 0, 5, 0, 0};
        vecs[3] = '{4, 4, 0, 3, 16, 0};
        vecs[4] = '{1, 1, 0, 1, 1, 0};
        vecs[5] = '{5, 1, 1, 2, 5, 8};
        vecs[6] = '{1, 4, 0, 7, 4, 0};
        vecs[7] = '{2, 3, 1, 0, 6, 10};
        vecs[8] = '{7, 0, 0, 1, 0, 0};

        reset = 1'b1; start = 1'b0; width = '0; height = '0;
        ray_valid = 1'b0; pif.pix_ready = 1'b0;
        tick(); tick();
        check("rst_valid", pif.pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_perr", protocol_err, 0);
        check("rst_x", pif.pix_x, 0);
        check("rst_last", pif.pix_last, 0);
        reset = 1'b0;
        tick();

        foreach (vecs[i])
            run_frame(vecs[i].w, vecs[i].h, vecs[i].rmode, vecs[i].lat,
                      vecs[i].exp_pix, vecs[i].exp_stall, 1'b0);

        // Start pulsed mid-scan must not disturb a 4x4 frame.
        run_frame(4, 4, 0, 2, 16, 0, 1'b1);

        // Stray ray while idle sets a sticky error; the next frame's start clears it.
        ray_valid = 1'b1;
        tick();
        ray_valid = 1'b0;
        check("perr_set", protocol_err, 1);
        tick(); tick();
        check("perr_sticky", protocol_err, 1);
        check("perr_idle", busy, 0);
        run_frame(2, 1, 0, 1, 2, 0, 1'b0);

        // Reset after the third transfer of a 4x4 frame aborts it immediately.
        start = 1'b1; width = 16'd4; height = 16'd4; pif.pix_ready = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("abort_pre_x", pif.pix_x, 64'd3 * 64'h40000);
        reset = 1'b1;
        #1;
        check("abort_valid", pif.pix_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_x", pif.pix_x, 0);
        check("abort_y", pif.pix_y, 0);
        check("abort_last", pif.pix_last, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", done, 0);
        end
        reset = 1'b0;
        pif.pix_ready = 1'b0;
        tick();
        check("abort_idle", busy, 0);
        run_frame(2, 2, 0, 3, 4, 0, 1'b0);

        // Random frames against the same raster model.
        for (int r = 0; r < 6; r++) begin
            w = int'($urandom_range(0, 6));
            h = int'($urandom_range(1, 5));
            nx = w * h;
            run_frame(w, h, 2, 0, nx, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
